phase_eval_seq: RTL

PHASE_EVAL_SEQ -- requirements
Module: phase_eval_seq

---
 rtl/phase_pkg.sv | 24 ++
 rtl/atan_lut.sv | 76 +++++++
 rtl/phase_eval_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/phase_pkg.sv
// Shared definitions for the phase evaluation sequencer.
//   PI_Q / TWO_PI_Q : angle constants in the atan_lut Q2.13 radian format
//   ANG_W           : width of one lookup angle
//   state_t         : sequencer states
//   phase_w()       : width of the running phase for a given lane count
package phase_pkg;

  localparam int ANG_W    = 16;
  localparam int PI_Q     = 25736;
  localparam int TWO_PI_Q = 51472;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ZERO = 2'd1,
    ST_POLE = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // One sign bit plus 16 angle bits, plus headroom for summing every lane.
  function automatic int phase_w(input int n_zeros, input int n_poles);
    return 17 + $clog2(n_zeros + n_poles);
  endfunction

endpackage

// File: rtl/atan_lut.sv
// Combinational four-quadrant arctangent of (re, im).
// Ports:
//   re, im : signed 16-bit vector components (full range, -32768 allowed)
//   angle  : signed Q2.13 radians in [-PI_Q, PI_Q]
// Exact axis results are produced directly; other vectors go through a
// 14-step vectoring CORDIC after folding into the right half-plane.
module atan_lut
  import phase_pkg::*;
(
  input  logic signed [ANG_W-1:0] re,
  input  logic signed [ANG_W-1:0] im,
  output logic signed [ANG_W-1:0] angle
);

  localparam int XY_W  = 20;
  localparam int Z_W   = 18;
  localparam int STEPS = 14;

  logic signed [XY_W-1:0] x, y, xn, yn;
  logic signed [Z_W-1:0]  z;

  function automatic logic signed [Z_W-1:0] atan_step(input int i);
    case (i)
      0:       return 18'sd6434;
      1:       return 18'sd3798;
      2:       return 18'sd2007;
      3:       return 18'sd1019;
      4:       return 18'sd511;
      5:       return 18'sd256;
      6:       return 18'sd128;
      7:       return 18'sd64;
      8:       return 18'sd32;
      9:       return 18'sd16;
      10:      return 18'sd8;
      11:      return 18'sd4;
      12:      return 18'sd2;
      default: return 18'sd1;
    endcase
  endfunction

  always_comb begin
    x     = XY_W'(re);
    y     = XY_W'(im);
    xn    = '0;
    yn    = '0;
    z     = '0;
    angle = '0;
    if (im == '0) begin
      angle = (re < 0) ? ANG_W'(PI_Q) : '0;
    end else if (re == '0) begin
      angle = (im > 0) ? ANG_W'(PI_Q / 2) : ANG_W'(-(PI_Q / 2));
    end else begin
      // Widened before negation so -32768 folds without overflow.
      if (re < 0) begin
        x = -x;
        y = -y;
        z = (im > 0) ? Z_W'(PI_Q) : Z_W'(-PI_Q);
      end
      for (int i = 0; i < STEPS; i++) begin
        if (y > 0) begin
          xn = x + (y >>> i);
          yn = y - (x >>> i);
          z  = z + atan_step(i);
        end else begin
          xn = x - (y >>> i);
          yn = y + (x >>> i);
          z  = z - atan_step(i);
        end
        x = xn;
        y = yn;
      end
      angle = z[ANG_W-1:0];
    end
  end

endmodule

// File: rtl/phase_eval_seq.sv
// Phase evaluation sequencer: sums zero-lane angles and subtracts pole-lane
// angles, one lane per cycle through a single shared atan_lut.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   in_valid / in_ready        : request handshake (ready only when idle)
//   zero_diff_re/_im, zero_en  : packed signed zero lanes + enables
//   pole_diff_re/_im, pole_en  : packed signed pole lanes + enables
//   out_valid / out_ready      : result handshake
//   phase_out                  : accumulated phase, Q2.13 radians
//   degenerate                 : an enabled lane had re = im = 0
//
// state   | meaning
// IDLE    | waiting for a request, in_ready high
// ZERO    | adding zero lane angles, lane 0 upward
// POLE    | subtracting pole lane angles, lane 0 upward
// DONE    | result held on outputs until out_ready
module phase_eval_seq
  import phase_pkg::*;
#(
  parameter  int N_ZEROS = 4,
  parameter  int N_POLES = 4,
  parameter  int WRAP_EN = 0,
  localparam int PHASE_W = phase_w(N_ZEROS, N_POLES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [16*N_ZEROS-1:0]       zero_diff_re,
  input  logic [16*N_ZEROS-1:0]       zero_diff_im,
  input  logic [16*N_POLES-1:0]       pole_diff_re,
  input  logic [16*N_POLES-1:0]       pole_diff_im,
  input  logic [N_ZEROS-1:0]          zero_en,
  input  logic [N_POLES-1:0]          pole_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [PHASE_W-1:0]   phase_out,
  output logic                        degenerate
);

  localparam int N_MAX  = (N_ZEROS > N_POLES) ? N_ZEROS : N_POLES;
  localparam int LANE_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam logic signed [PHASE_W-1:0] PI_W     = PHASE_W'(PI_Q);
  localparam logic signed [PHASE_W-1:0] TWO_PI_W = PHASE_W'(TWO_PI_Q);
  localparam logic [LANE_W-1:0] LAST_Z = LANE_W'(N_ZEROS - 1);
  localparam logic [LANE_W-1:0] LAST_P = LANE_W'(N_POLES - 1);

  state_t                      state_q, state_d;
  logic [LANE_W-1:0]           lane_q, lane_d;
  logic signed [PHASE_W-1:0]   acc_q, acc_d;
  logic                        degen_q, degen_d;
  logic [16*N_ZEROS-1:0]       zre_q, zre_d, zim_q, zim_d;
  logic [16*N_POLES-1:0]       pre_q, pre_d, pim_q, pim_d;
  logic [N_ZEROS-1:0]          zen_q, zen_d;
  logic [N_POLES-1:0]          pen_q, pen_d;

  logic signed [ANG_W-1:0]     lane_re, lane_im, lane_ang;
  logic                        lane_en, lane_zero;
  logic signed [PHASE_W-1:0]   contrib, sum;

  always_comb begin
    lane_re = '0;
    lane_im = '0;
    lane_en = 1'b0;
    if (state_q == ST_ZERO) begin
      for (int k = 0; k < N_ZEROS; k++) begin
        if (lane_q == LANE_W'(k)) begin
          lane_re = zre_q[16*k +: 16];
          lane_im = zim_q[16*k +: 16];
          lane_en = zen_q[k];
        end
      end
    end else if (state_q == ST_POLE) begin
      for (int k = 0; k < N_POLES; k++) begin
        if (lane_q == LANE_W'(k)) begin
          lane_re = pre_q[16*k +: 16];
          lane_im = pim_q[16*k +: 16];
          lane_en = pen_q[k];
        end
      end
    end
  end

  atan_lut u_atan (
    .re    (lane_re),
    .im    (lane_im),
    .angle (lane_ang)
  );

  always_comb begin
    lane_zero = (lane_re == '0) && (lane_im == '0);
    contrib   = '0;
    if (lane_en && !lane_zero) begin
      contrib = PHASE_W'(lane_ang);
    end
    sum = (state_q == ST_POLE) ? (acc_q - contrib) : (acc_q + contrib);
    // Accumulator stays inside [-PI, PI), so a single correction suffices.
    if (WRAP_EN != 0) begin
      if (sum >= PI_W) begin
        sum = sum - TWO_PI_W;
      end else if (sum < -PI_W) begin
        sum = sum + TWO_PI_W;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    acc_d   = acc_q;
    degen_d = degen_q;
    zre_d   = zre_q;
    zim_d   = zim_q;
    pre_d   = pre_q;
    pim_d   = pim_q;
    zen_d   = zen_q;
    pen_d   = pen_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          zre_d   = zero_diff_re;
          zim_d   = zero_diff_im;
          pre_d   = pole_diff_re;
          pim_d   = pole_diff_im;
          zen_d   = zero_en;
          pen_d   = pole_en;
          acc_d   = '0;
          degen_d = 1'b0;
          lane_d  = '0;
          state_d = ST_ZERO;
        end
      end
      ST_ZERO, ST_POLE: begin
        acc_d = sum;
        if (lane_en && lane_zero) begin
          degen_d = 1'b1;
        end
        if ((state_q == ST_ZERO) && (lane_q == LAST_Z)) begin
          lane_d  = '0;
          state_d = ST_POLE;
        end else if ((state_q == ST_POLE) && (lane_q == LAST_P)) begin
          lane_d  = '0;
          state_d = ST_DONE;
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      acc_q   <= '0;
      degen_q <= 1'b0;
      zre_q   <= '0;
      zim_q   <= '0;
      pre_q   <= '0;
      pim_q   <= '0;
      zen_q   <= '0;
      pen_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      acc_q   <= acc_d;
      degen_q <= degen_d;
      zre_q   <= zre_d;
      zim_q   <= zim_d;
      pre_q   <= pre_d;
      pim_q   <= pim_d;
      zen_q   <= zen_d;
      pen_q   <= pen_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign phase_out  = acc_q;
  assign degenerate = degen_q;

endmodule
